// File: rtl/video_sync_tracker.sv
// Recovers raster timing (line period, frame height, position) from hsync/vsync alone.
// Locks after consistent frames and then flags any phase or period disturbance.
module video_sync_tracker #(
   parameter int H_VISIBLE    = 640,
   parameter int H_SYNC_START = 656,
   parameter int V_VISIBLE    = 480,
   parameter int V_SYNC_START = 490,
   parameter int LOCK_FRAMES  = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_hsync,
   input  logic       i_vsync,
   output logic       o_locked,
   output logic       o_error,
   output logic [9:0] o_h_total,
   output logic [9:0] o_v_total,
   output logic [9:0] o_hpos,
   output logic [9:0] o_vpos,
   output logic       o_visible,
   output logic       o_frame_start
);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   localparam logic [9:0] HSS   = 10'(H_SYNC_START);
   localparam logic [9:0] HSS1  = 10'(H_SYNC_START + 1);
   localparam logic [9:0] VSS   = 10'(V_SYNC_START);
   localparam logic [9:0] HVIS  = 10'(H_VISIBLE);
   localparam logic [9:0] VVIS  = 10'(V_VISIBLE);
   localparam logic [2:0] LOCKN = 3'(LOCK_FRAMES);
   localparam logic [9:0] PMAX  = 10'd1023;

   state_t     state_q, state_d;
   logic       hs_q, vs_q;
   logic [9:0] hper_q, hper_d, lines_q, lines_d;
   logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic [9:0] h_total_q, h_total_d, v_total_q, v_total_d;
   logic       vseen_q, vseen_d, frame_bad_q, frame_bad_d, error_q, error_d;
   logic [2:0] good_q, good_d;
   logic       hs_rise, vs_rise, timeout, lose_lock;

   assign hs_rise = i_hsync & ~hs_q;
   assign vs_rise = i_vsync & ~vs_q;

   // Measurement and free-running position counters; they run in every state.
   always_comb begin
      hper_d  = hs_rise ? 10'd1 : ((hper_q == PMAX) ? hper_q : hper_q + 10'd1);
      timeout = (hper_d == PMAX);

      lines_d = lines_q;
      if (vs_rise)
         lines_d = {9'd0, hs_rise};
      else if (hs_rise)
         lines_d = lines_q + 10'd1;

      hcnt_d = hcnt_q + 10'd1;
      vcnt_d = vcnt_q;
      if (hs_rise) begin
         hcnt_d = HSS1;
      end else if (hcnt_q == h_total_q - 10'd1) begin
         hcnt_d = 10'd0;
         vcnt_d = (vcnt_q == v_total_q - 10'd1) ? 10'd0 : vcnt_q + 10'd1;
      end
      if (vs_rise)
         vcnt_d = VSS;
   end

   always_comb begin
      state_d     = state_q;
      h_total_d   = h_total_q;
      v_total_d   = v_total_q;
      vseen_d     = vseen_q;
      good_d      = good_q;
      frame_bad_d = frame_bad_q;
      error_d     = 1'b0;
      lose_lock   = (hs_rise && (hcnt_q != HSS || hper_q != h_total_q)) ||
                    (vs_rise && (vcnt_q != VSS || hcnt_q != 10'd0));

      case (state_q)
         SEARCH: begin
            vseen_d = 1'b0;
            good_d  = 3'd0;
            if (hs_rise)
               state_d = MEASURE;
         end
         MEASURE: begin
            // The first vsync only opens a frame; later ones close and compare it.
            if (vs_rise) begin
               if (!vseen_q) begin
                  vseen_d = 1'b1;
               end else if (lines_q == v_total_q && !frame_bad_q) begin
                  good_d = good_q + 3'd1;
                  if (good_q + 3'd1 == LOCKN)
                     state_d = LOCKED;
               end else begin
                  good_d    = 3'd0;
                  v_total_d = lines_q;
               end
               frame_bad_d = 1'b0;
            end
            if (hs_rise && hper_q != h_total_q) begin
               h_total_d   = hper_q;
               frame_bad_d = 1'b1;
            end
         end
         LOCKED: begin
            if (lose_lock) begin
               state_d = MEASURE;
               good_d  = 3'd0;
               vseen_d = 1'b0;
               error_d = 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase

      if (timeout) begin
         state_d = SEARCH;
         error_d = (state_q == LOCKED);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= SEARCH;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         hper_q      <= 10'd0;
         lines_q     <= 10'd0;
         hcnt_q      <= 10'd0;
         vcnt_q      <= 10'd0;
         h_total_q   <= 10'd0;
         v_total_q   <= 10'd0;
         vseen_q     <= 1'b0;
         frame_bad_q <= 1'b0;
         error_q     <= 1'b0;
         good_q      <= 3'd0;
      end else begin
         state_q     <= state_d;
         hs_q        <= i_hsync;
         vs_q        <= i_vsync;
         hper_q      <= hper_d;
         lines_q     <= lines_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         h_total_q   <= h_total_d;
         v_total_q   <= v_total_d;
         vseen_q     <= vseen_d;
         frame_bad_q <= frame_bad_d;
         error_q     <= error_d;
         good_q      <= good_d;
      end
   end

   assign o_locked      = (state_q == LOCKED);
   assign o_error       = error_q;
   assign o_h_total     = h_total_q;
   assign o_v_total     = v_total_q;
   assign o_hpos        = hcnt_q;
   assign o_vpos        = vcnt_q;
   assign o_visible     = o_locked && (hcnt_q < HVIS) && (vcnt_q < VVIS);
   assign o_frame_start = o_locked && (hcnt_q == 10'd0) && (vcnt_q == 10'd0);

endmodule

// File: tb/tb_video_sync_tracker.sv
// Directed bench for video_sync_tracker: a sync source model drives the DUT and
// expectations are queued with a due cycle and checked when that cycle is sampled.
module tb_video_sync_tracker;

   localparam int M_HV = 40, M_HSS = 44, M_HSW = 8, M_HT = 56;
   localparam int M_VV = 30, M_VSS = 32, M_VSW = 2, M_VT = 36;
   localparam int S_HV = 12, S_HSS = 14, S_HSW = 2, S_HT = 20;
   localparam int S_VV = 6,  S_VSS = 7,  S_VSW = 2, S_VT = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       m_rst_n, m_hs, m_vs, m_locked, m_error, m_visible, m_fs;
   logic [9:0] m_htot, m_vtot, m_hpos, m_vpos;
   logic       s_rst_n, s_hs, s_vs, s_locked, s_error, s_visible, s_fs;
   logic [9:0] s_htot, s_vtot, s_hpos, s_vpos;

   video_sync_tracker #(
      .H_VISIBLE(M_HV), .H_SYNC_START(M_HSS), .V_VISIBLE(M_VV),
      .V_SYNC_START(M_VSS), .LOCK_FRAMES(2)
   ) dut_main (
      .i_clk(clk), .i_rst_n(m_rst_n), .i_hsync(m_hs), .i_vsync(m_vs),
      .o_locked(m_locked), .o_error(m_error), .o_h_total(m_htot), .o_v_total(m_vtot),
      .o_hpos(m_hpos), .o_vpos(m_vpos), .o_visible(m_visible), .o_frame_start(m_fs)
   );

   video_sync_tracker #(
      .H_VISIBLE(S_HV), .H_SYNC_START(S_HSS), .V_VISIBLE(S_VV),
      .V_SYNC_START(S_VSS), .LOCK_FRAMES(1)
   ) dut_small (
      .i_clk(clk), .i_rst_n(s_rst_n), .i_hsync(s_hs), .i_vsync(s_vs),
      .o_locked(s_locked), .o_error(s_error), .o_h_total(s_htot), .o_v_total(s_vtot),
      .o_hpos(s_hpos), .o_vpos(s_vpos), .o_visible(s_visible), .o_frame_start(s_fs)
   );

   typedef struct {
      string tag;
      int    sig;
      int    due;
      int    exp;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, errors = 0;
   int   cyc = 0, sel = 0;
   int   src_ht, src_hss, src_hsw, src_vt, src_vss, src_vsw, src_hv, src_vv;
   int   sx = 0, sy = 0, hs_n = 0, vs_n = 0;
   int   vis_cnt = 0, fs_cnt = 0, err_cnt = 0, err0 = 0, n = 0;
   bit   hs_en = 1, vs_en = 1, stall_req = 0, chk_pos = 0, chk_ev = 0;
   bit   hs_prev = 0, vs_prev = 0;

   // sig: 0 locked, 1 error, 2 h_total, 3 v_total, 4 hpos, 5 vpos, 6 visible, 7 frame_start
   function automatic int obs(int sig);
      int r;
      r = -1;
      if (sel == 0) begin
         case (sig)
            0: r = int'(m_locked);
            1: r = int'(m_error);
            2: r = int'(m_htot);
            3: r = int'(m_vtot);
            4: r = int'(m_hpos);
            5: r = int'(m_vpos);
            6: r = int'(m_visible);
            7: r = int'(m_fs);
            default: r = -1;
         endcase
      end else begin
         case (sig)
            0: r = int'(s_locked);
            1: r = int'(s_error);
            2: r = int'(s_htot);
            3: r = int'(s_vtot);
            4: r = int'(s_hpos);
            5: r = int'(s_vpos);
            6: r = int'(s_visible);
            7: r = int'(s_fs);
            default: r = -1;
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string tag, input int o, input int e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, o, e, cyc);
      end
   endtask

   task automatic expect_at(input string tag, input int sig, input int e, input int off);
      exp_t x;
      x.tag = tag;
      x.sig = sig;
      x.due = cyc + off;
      x.exp = e;
      exp_q.push_back(x);
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (i < exp_q.size()) begin
         if (exp_q[i].due <= cyc) begin
            chk(exp_q[i].tag, obs(exp_q[i].sig), exp_q[i].exp);
            exp_q.delete(i);
         end else begin
            i++;
         end
      end
   endtask

   task automatic set_src(input int ht, input int hss, input int hsw, input int hv,
                          input int vt, input int vss, input int vsw, input int vv);
      src_ht = ht; src_hss = hss; src_hsw = hsw; src_hv = hv;
      src_vt = vt; src_vss = vss; src_vsw = vsw; src_vv = vv;
   endtask

   task automatic src_restart();
      sx = 0; sy = 0; hs_n = 0; vs_n = 0;
   endtask

   // One source clock: drive the sync levels for (sx,sy), queue position
   // expectations, sample the DUT, then advance the source raster.
   task automatic step();
      bit hs, vs, stalled;
      int px;
      @(negedge clk);
      cyc++;
      stalled = stall_req && (sx == src_hss);
      px = stalled ? sx - 1 : sx;
      hs = hs_en && (px >= src_hss) && (px < src_hss + src_hsw);
      vs = vs_en && (sy >= src_vss) && (sy < src_vss + src_vsw);
      if (sel == 0) begin m_hs = hs; m_vs = vs; end
      else          begin s_hs = hs; s_vs = vs; end
      if (hs && !hs_prev) begin
         hs_n++;
         if (chk_ev) expect_at("hpos_at_hs_rise", 4, src_hss, 0);
      end
      if (vs && !vs_prev) begin
         vs_n++;
         if (chk_ev) begin
            expect_at("vpos_at_vs_rise", 5, src_vss, 0);
            expect_at("hpos_at_vs_rise", 4, 0, 0);
         end
      end
      if (chk_pos && !stalled) begin
         expect_at("hpos_track", 4, sx, 0);
         expect_at("vpos_track", 5, sy, 0);
         expect_at("visible_track", 6, int'(sx < src_hv && sy < src_vv), 0);
         expect_at("frame_start_track", 7, int'(sx == 0 && sy == 0), 0);
      end
      vis_cnt += obs(6);
      fs_cnt  += obs(7);
      err_cnt += obs(1);
      drain();
      hs_prev = hs;
      vs_prev = vs;
      if (stalled) begin
         stall_req = 0;
      end else begin
         sx++;
         if (sx == src_ht) begin
            sx = 0;
            sy = (sy + 1) % src_vt;
         end
      end
   endtask

   task automatic run_cycles(input int k);
      repeat (k) step();
   endtask

   task automatic run_until_hs(input int target, input string tag);
      int k;
      k = 0;
      while (hs_n < target && k < 5000) begin step(); k++; end
      chk(tag, hs_n, target);
   endtask

   task automatic run_until_vs(input int target, input string tag);
      int k;
      k = 0;
      while (vs_n < target && k < 40000) begin step(); k++; end
      chk(tag, vs_n, target);
   endtask

   task automatic run_until_frame();
      int k;
      k = 0;
      while (!(sx == 0 && sy == 0) && k < 5000) begin step(); k++; end
      chk("frame_start_reached", int'(sx == 0 && sy == 0), 1);
   endtask

   initial begin
      m_rst_n = 1'b0; s_rst_n = 1'b0;
      m_hs = 1'b0; m_vs = 1'b0; s_hs = 1'b0; s_vs = 1'b0;
      sel = 0;
      set_src(M_HT, M_HSS, M_HSW, M_HV, M_VT, M_VSS, M_VSW, M_VV);

      // Reset state
      run_cycles(2);
      for (int s = 0; s < 8; s++) expect_at($sformatf("reset_sig%0d", s), s, 0, 1);
      run_cycles(1);
      m_rst_n = 1'b1;
      src_restart();

      // Acquisition from reset
      run_until_hs(1, "s1_hs1_reached");
      expect_at("s1_h_total_after_hs1", 2, 0, 1);
      run_until_hs(2, "s1_hs2_reached");
      expect_at("s1_h_total_after_hs2", 2, M_HT, 1);
      run_until_vs(1, "s1_vs1_reached");
      expect_at("s1_v_total_after_vs1", 3, 0, 1);
      run_until_vs(2, "s1_vs2_reached");
      expect_at("s1_v_total_after_vs2", 3, M_VT, 1);
      run_until_vs(3, "s1_vs3_reached");
      expect_at("s1_unlocked_after_vs3", 0, 0, 1);
      run_until_vs(4, "s1_vs4_reached");
      expect_at("s1_locked_after_vs4", 0, 1, 1);
      run_cycles(1);
      chk("s1_no_error_pulse", err_cnt, 0);

      // Locked tracking over one full frame
      run_until_frame();
      chk_pos = 1; chk_ev = 1; vis_cnt = 0; fs_cnt = 0;
      run_cycles(M_HT * M_VT);
      chk_pos = 0;
      chk("s2_visible_per_frame", vis_cnt, M_HV * M_VV);
      chk("s2_frame_start_per_frame", fs_cnt, 1);

      // One hsync delayed by a clock, new phase kept
      err0 = err_cnt;
      chk_ev = 0;
      while (sx != 1) step();
      stall_req = 1;
      n = hs_n + 1;
      run_until_hs(n, "s3_late_hs_reached");
      expect_at("s3_unlocked_after_late_hs", 0, 0, 1);
      expect_at("s3_error_pulse", 1, 1, 1);
      expect_at("s3_error_one_cycle", 1, 0, 2);
      vs_n = 0;
      run_until_vs(2, "s3_vs2_reached");
      expect_at("s3_unlocked_after_vs2", 0, 0, 1);
      run_until_vs(3, "s3_vs3_reached");
      expect_at("s3_relocked_after_vs3", 0, 1, 1);
      run_cycles(1);
      chk_ev = 1;
      n = hs_n + 1;
      run_until_hs(n, "s3_post_lock_hs_reached");
      n = vs_n + 1;
      run_until_vs(n, "s3_post_lock_vs_reached");
      chk("s3_single_error", err_cnt - err0, 1);

      // hsync stops: timeout 1022 clocks after the last rising edge
      n = hs_n + 1;
      run_until_hs(n, "s4_last_hs_reached");
      hs_en = 0; vs_en = 0; chk_ev = 0;
      err0 = err_cnt;
      expect_at("s4_still_locked_1021", 0, 1, 1022);
      expect_at("s4_no_error_yet", 1, 0, 1022);
      expect_at("s4_unlocked_1022", 0, 0, 1023);
      expect_at("s4_error_pulse", 1, 1, 1023);
      expect_at("s4_error_one_cycle", 1, 0, 1024);
      expect_at("s4_h_total_held", 2, M_HT, 1030);
      expect_at("s4_v_total_held", 3, M_VT, 1030);
      run_cycles(1040);
      chk("s4_single_error", err_cnt - err0, 1);
      hs_en = 1; vs_en = 1;
      src_restart();
      run_until_vs(2, "s4_vs2_reached");
      expect_at("s4_unlocked_after_vs2", 0, 0, 1);
      run_until_vs(3, "s4_vs3_reached");
      expect_at("s4_relocked_after_vs3", 0, 1, 1);
      run_cycles(1);

      // Asynchronous reset between clock edges
      run_cycles(500);
      #2;
      m_rst_n = 1'b0;
      #1;
      for (int s = 0; s < 8; s++) chk($sformatf("s5_async_reset_sig%0d", s), obs(s), 0);
      run_cycles(3);
      m_rst_n = 1'b1;
      src_restart();
      err0 = err_cnt;
      run_until_vs(2, "s5_vs2_reached");
      expect_at("s5_v_total_after_vs2", 3, M_VT, 1);
      run_until_vs(3, "s5_vs3_reached");
      expect_at("s5_unlocked_after_vs3", 0, 0, 1);
      run_until_vs(4, "s5_vs4_reached");
      expect_at("s5_locked_after_vs4", 0, 1, 1);
      run_cycles(1);
      chk("s5_no_error_pulse", err_cnt - err0, 0);

      // Small raster, LOCK_FRAMES=1
      sel = 1;
      set_src(S_HT, S_HSS, S_HSW, S_HV, S_VT, S_VSS, S_VSW, S_VV);
      hs_prev = 0; vs_prev = 0;
      s_rst_n = 1'b1;
      src_restart();
      err0 = err_cnt;
      run_until_hs(2, "s6_hs2_reached");
      expect_at("s6_h_total", 2, S_HT, 1);
      run_until_vs(2, "s6_vs2_reached");
      expect_at("s6_v_total", 3, S_VT, 1);
      expect_at("s6_unlocked_after_vs2", 0, 0, 1);
      run_until_vs(3, "s6_vs3_reached");
      expect_at("s6_locked_after_vs3", 0, 1, 1);
      run_until_frame();
      chk_pos = 1; chk_ev = 1; vis_cnt = 0; fs_cnt = 0;
      run_cycles(S_HT * S_VT);
      chk_pos = 0; chk_ev = 0;
      chk("s6_visible_per_frame", vis_cnt, S_HV * S_VV);
      chk("s6_frame_start_per_frame", fs_cnt, 1);
      chk("s6_no_error_pulse", err_cnt - err0, 0);

      run_cycles(2);
      chk("expectations_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
